// File: rtl/resnet_stream_sequencer.sv
// Run-level sequencer for the resnet accelerator. It flushes the core, hands out linear
// read addresses for the input and kernel streams, and counts write-backs until completion or timeout.
module resnet_stream_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int N_INPUT   = 4096,
  parameter int N_KERNEL  = 576,
  parameter int N_OUTPUT  = 4096,
  parameter int FLUSH_CYC = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_overrun,
  output logic              dut_flush,
  input  logic              in_read_en,
  output logic [ADDR_W-1:0] in_addr,
  input  logic              k_read_en,
  output logic [ADDR_W-1:0] k_addr,
  input  logic              out_valid,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr
);

  typedef enum logic [1:0] {IDLE, FLUSH, RUN, DONE} state_t;

  localparam logic [ADDR_W-1:0] N_IN_C  = ADDR_W'(N_INPUT);
  localparam logic [ADDR_W-1:0] N_K_C   = ADDR_W'(N_KERNEL);
  localparam logic [ADDR_W-1:0] N_OUT_C = ADDR_W'(N_OUTPUT);
  localparam logic [ADDR_W-1:0] FLUSH_C = ADDR_W'(FLUSH_CYC);
  localparam logic [ADDR_W-1:0] TO_C    = ADDR_W'(TIMEOUT);

  state_t            state;
  logic [ADDR_W-1:0] in_cnt;
  logic [ADDR_W-1:0] k_cnt;
  logic [ADDR_W-1:0] out_cnt;
  logic [ADDR_W-1:0] idle_cnt;
  logic [ADDR_W-1:0] flush_cnt;
  logic              in_run;
  logic              last_out;

  assign in_run   = (state == RUN);
  assign out_we   = out_valid & in_run;
  assign last_out = out_we && (out_cnt == N_OUT_C - 1'b1);

  // Once a stream is exhausted its address parks on the final word instead of running off the end.
  assign in_addr  = (in_cnt == N_IN_C) ? N_IN_C - 1'b1 : in_cnt;
  assign k_addr   = (k_cnt == N_K_C) ? N_K_C - 1'b1 : k_cnt;
  assign out_addr = out_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_cnt      <= '0;
      k_cnt       <= '0;
      out_cnt     <= '0;
      idle_cnt    <= '0;
      flush_cnt   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dut_flush   <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state       <= FLUSH;
            busy        <= 1'b1;
            dut_flush   <= 1'b1;
            in_cnt      <= '0;
            k_cnt       <= '0;
            out_cnt     <= '0;
            idle_cnt    <= '0;
            flush_cnt   <= '0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
          end
        end

        FLUSH: begin
          if (flush_cnt == FLUSH_C - 1'b1) begin
            state     <= RUN;
            dut_flush <= 1'b0;
            idle_cnt  <= '0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end

        RUN: begin
          if (in_read_en) begin
            if (in_cnt == N_IN_C) err_overrun <= 1'b1;
            else                  in_cnt      <= in_cnt + 1'b1;
          end
          if (k_read_en) begin
            if (k_cnt == N_K_C) err_overrun <= 1'b1;
            else                k_cnt       <= k_cnt + 1'b1;
          end

          if (out_valid) begin
            out_cnt  <= out_cnt + 1'b1;
            idle_cnt <= '0;
          end else if (idle_cnt != TO_C) begin
            idle_cnt <= idle_cnt + 1'b1;
          end

          // The final output beats a timeout that lands on the same cycle.
          if (last_out) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (idle_cnt == TO_C) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            err_timeout <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_resnet_stream_sequencer.sv
// Directed bench for resnet_stream_sequencer with small stream lengths.
// Inputs change 1ns after the rising edge; outputs are sampled in the same window.
module tb_resnet_stream_sequencer;
  localparam int ADDR_W    = 16;
  localparam int N_INPUT   = 8;
  localparam int N_KERNEL  = 4;
  localparam int N_OUTPUT  = 6;
  localparam int FLUSH_CYC = 2;
  localparam int TIMEOUT   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_read_en = 1'b0;
  logic              k_read_en = 1'b0;
  logic              out_valid = 1'b0;
  logic              busy, done, err_timeout, err_overrun, dut_flush, out_we;
  logic [ADDR_W-1:0] in_addr, k_addr, out_addr;

  int tests = 0;
  int fails = 0;

  resnet_stream_sequencer #(
    .ADDR_W(ADDR_W), .N_INPUT(N_INPUT), .N_KERNEL(N_KERNEL),
    .N_OUTPUT(N_OUTPUT), .FLUSH_CYC(FLUSH_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .dut_flush(dut_flush),
    .in_read_en(in_read_en), .in_addr(in_addr), .k_read_en(k_read_en), .k_addr(k_addr),
    .out_valid(out_valid), .out_we(out_we), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse start and step through FLUSH, returning how many cycles dut_flush was high.
  task automatic start_run(output int flush_cycles);
    start = 1'b1;
    tick();
    start = 1'b0;
    flush_cycles = 0;
    for (int i = 0; i < 10 && dut_flush; i++) begin
      flush_cycles++;
      tick();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    tests++;
    if ({busy, done, dut_flush, err_timeout, err_overrun, out_we} !== 6'b0) begin
      fails++;
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {busy, done, dut_flush, err_timeout, err_overrun, out_we});
    end
    tests++;
    if ({in_addr, k_addr, out_addr} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_addr: got in=%0d k=%0d out=%0d expected 0/0/0", in_addr, k_addr, out_addr);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nominal;
    int fc;
    start_run(fc);
    tests++;
    if (fc !== FLUSH_CYC || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL nominal_flush: got %0d cycles busy=%b expected %0d busy=1", fc, busy, FLUSH_CYC);
    end
    // Both streams fire together for the first N_KERNEL reads.
    for (int i = 0; i < N_INPUT; i++) begin
      in_read_en = 1'b1;
      k_read_en  = (i < N_KERNEL);
      #1;
      tests++;
      if (in_addr !== ADDR_W'(i) || k_addr !== ADDR_W'((i < N_KERNEL) ? i : N_KERNEL - 1)) begin
        fails++;
        $display("[TB] FAIL nominal_read[%0d]: got in=%0d k=%0d expected in=%0d k=%0d",
                 i, in_addr, k_addr, i, (i < N_KERNEL) ? i : N_KERNEL - 1);
      end
      tick();
    end
    in_read_en = 1'b0;
    k_read_en  = 1'b0;
    for (int i = 0; i < N_OUTPUT; i++) begin
      out_valid = 1'b1;
      #1;
      tests++;
      if (out_we !== 1'b1 || out_addr !== ADDR_W'(i) || done !== 1'b0) begin
        fails++;
        $display("[TB] FAIL nominal_write[%0d]: got we=%b addr=%0d done=%b expected 1/%0d/0",
                 i, out_we, out_addr, done, i);
      end
      tick();
    end
    out_valid = 1'b0;
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || err_timeout !== 1'b0 || err_overrun !== 1'b0) begin
      fails++;
      $display("[TB] FAIL nominal_done: got done=%b busy=%b to=%b ov=%b expected 1/0/0/0",
               done, busy, err_timeout, err_overrun);
    end
    tick();
    tests++;
    if (done !== 1'b0 || in_addr !== 16'd7 || k_addr !== 16'd3 || out_addr !== 16'd6) begin
      fails++;
      $display("[TB] FAIL nominal_after: got done=%b in=%0d k=%0d out=%0d expected 0/7/3/6",
               done, in_addr, k_addr, out_addr);
    end
  endtask

  task automatic test_timeout;
    int fc;
    int n;
    start_run(fc);
    for (int i = 0; i < 3; i++) begin
      out_valid = 1'b1;
      tick();
    end
    out_valid = 1'b0;
    // idle_cnt reaches TIMEOUT after TIMEOUT quiet edges; the next edge enters DONE.
    n = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      n++;
    end
    tests++;
    if (n !== TIMEOUT + 1) begin
      fails++;
      $display("[TB] FAIL timeout_latency: got %0d cycles expected %0d", n, TIMEOUT + 1);
    end
    tests++;
    if (done !== 1'b1 || err_timeout !== 1'b1 || out_addr !== 16'd3 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL timeout_flags: got done=%b to=%b out=%0d busy=%b expected 1/1/3/0",
               done, err_timeout, out_addr, busy);
    end
    tick();
    tests++;
    if (done !== 1'b0 || err_timeout !== 1'b1) begin
      fails++;
      $display("[TB] FAIL timeout_sticky: got done=%b to=%b expected 0/1", done, err_timeout);
    end
  endtask

  task automatic test_overrun;
    int fc;
    start_run(fc);
    tests++;
    if (err_timeout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL restart_clears_timeout: got %b expected 0", err_timeout);
    end
    for (int i = 0; i <= N_INPUT; i++) begin
      in_read_en = 1'b1;
      #1;
      tests++;
      if (in_addr !== ADDR_W'((i < N_INPUT) ? i : N_INPUT - 1) || err_overrun !== 1'b0) begin
        fails++;
        $display("[TB] FAIL overrun_read[%0d]: got in=%0d ov=%b expected in=%0d ov=0",
                 i, in_addr, err_overrun, (i < N_INPUT) ? i : N_INPUT - 1);
      end
      tick();
    end
    in_read_en = 1'b0;
    tests++;
    if (err_overrun !== 1'b1 || in_addr !== 16'd7) begin
      fails++;
      $display("[TB] FAIL overrun_flag: got ov=%b in=%0d expected 1/7", err_overrun, in_addr);
    end
    for (int i = 0; i < N_OUTPUT; i++) begin
      out_valid = 1'b1;
      tick();
    end
    out_valid = 1'b0;
    tests++;
    if (done !== 1'b1 || err_overrun !== 1'b1 || err_timeout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL overrun_done: got done=%b ov=%b to=%b expected 1/1/0", done, err_overrun, err_timeout);
    end
    tick();
  endtask

  task automatic test_reset_mid_run;
    int fc;
    int seen_done;
    start_run(fc);
    for (int i = 0; i < 3; i++) begin
      out_valid = 1'b1;
      tick();
    end
    out_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++;
    if ({busy, done, dut_flush, err_timeout, err_overrun} !== 5'b0 || {in_addr, k_addr, out_addr} !== '0) begin
      fails++;
      $display("[TB] FAIL midreset_state: got flags=%b in=%0d k=%0d out=%0d expected 0",
               {busy, done, dut_flush, err_timeout, err_overrun}, in_addr, k_addr, out_addr);
    end
    out_valid = 1'b1;
    #1;
    tests++;
    if (out_we !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_we: got %b expected 0", out_we);
    end
    out_valid = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) seen_done++;
    end
    tests++;
    if (seen_done !== 0) begin
      fails++;
      $display("[TB] FAIL midreset_no_done: got %0d pulses expected 0", seen_done);
    end
    start_run(fc);
    out_valid = 1'b1;
    #1;
    tests++;
    if (out_addr !== 16'd0 || in_addr !== 16'd0 || out_we !== 1'b1) begin
      fails++;
      $display("[TB] FAIL midreset_restart: got out=%0d in=%0d we=%b expected 0/0/1", out_addr, in_addr, out_we);
    end
    tick();
    out_valid = 1'b0;
  endtask

  task automatic test_ignored;
    // Entered in RUN with one output already written.
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || dut_flush !== 1'b0 || out_addr !== 16'd1) begin
      fails++;
      $display("[TB] FAIL ignore_start_run: got busy=%b flush=%b out=%0d expected 1/0/1", busy, dut_flush, out_addr);
    end
    for (int i = 1; i < N_OUTPUT; i++) begin
      out_valid = 1'b1;
      tick();
    end
    start = 1'b1;
    #1;
    tests++;
    if (done !== 1'b1 || out_we !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ignore_in_done: got done=%b we=%b expected 1/0", done, out_we);
    end
    tick();
    start = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || dut_flush !== 1'b0 || out_we !== 1'b0 || out_addr !== 16'd6) begin
      fails++;
      $display("[TB] FAIL ignore_start_done: got busy=%b flush=%b we=%b out=%0d expected 0/0/0/6",
               busy, dut_flush, out_we, out_addr);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || out_addr !== 16'd6) begin
      fails++;
      $display("[TB] FAIL ignore_valid_idle: got busy=%b out=%0d expected 0/6", busy, out_addr);
    end
    out_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < FLUSH_CYC; i++) begin
      out_valid  = 1'b1;
      in_read_en = 1'b1;
      #1;
      tests++;
      if (out_we !== 1'b0 || dut_flush !== 1'b1) begin
        fails++;
        $display("[TB] FAIL ignore_flush[%0d]: got we=%b flush=%b expected 0/1", i, out_we, dut_flush);
      end
      tick();
    end
    out_valid  = 1'b0;
    in_read_en = 1'b0;
    tests++;
    if (busy !== 1'b1 || dut_flush !== 1'b0 || out_addr !== 16'd0 || in_addr !== 16'd0) begin
      fails++;
      $display("[TB] FAIL ignore_flush_counts: got busy=%b flush=%b out=%0d in=%0d expected 1/0/0/0",
               busy, dut_flush, out_addr, in_addr);
    end
  endtask

  task automatic test_same_cycle;
    int early;
    // Entered on the first RUN cycle, idle_cnt freshly zeroed.
    for (int i = 0; i < N_OUTPUT - 1; i++) begin
      out_valid = 1'b1;
      tick();
    end
    out_valid = 1'b0;
    early = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (done) early++;
      tick();
    end
    tests++;
    if (early !== 0 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL same_cycle_early: got %0d done pulses busy=%b expected 0/1", early, busy);
    end
    // idle_cnt now equals TIMEOUT; the final output lands on this very cycle.
    out_valid = 1'b1;
    #1;
    tests++;
    if (out_we !== 1'b1 || out_addr !== 16'd5) begin
      fails++;
      $display("[TB] FAIL same_cycle_we: got we=%b out=%0d expected 1/5", out_we, out_addr);
    end
    tick();
    out_valid = 1'b0;
    tests++;
    if (done !== 1'b1 || err_timeout !== 1'b0 || out_addr !== 16'd6) begin
      fails++;
      $display("[TB] FAIL same_cycle_done: got done=%b to=%b out=%0d expected 1/0/6", done, err_timeout, out_addr);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_overrun();
    test_reset_mid_run();
    test_ignored();
    test_same_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
